serial_alu_ctrl: RTL and testbench

- Bit-serial ALU sequencer that time-shares one instance of the team's 1-bit full adder `FA` (ports c_out, sum, a, b, c_in) across a WIDTH-bit operation.
- Latches operands on a start handshake, then steps the FA LSB-first, one bit per cycle.
- Accumulates the result in a shift register and publishes registered result and flags with a one-cycle done pulse.
- Sits between the instruction/control logic and the FA datapath as the low-area alternative to a ripple-carry ALU.

---
 rtl/serial_alu_ctrl_if.sv | 15 +
 rtl/serial_alu_ctrl.sv | 112 +++++++++++
 tb/tb_serial_alu_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serial_alu_ctrl_if.sv
// serial_alu_ctrl_if: operand/opcode request and registered result/flags of the serial ALU
interface serial_alu_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;
    logic             zero;
    modport master(output start, op, a, b, input busy, done, result, c_out, ovf, zero);
    modport slave(input start, op, a, b, output busy, done, result, c_out, ovf, zero);
endinterface

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ADD/SUB/AND/XOR sequencer time-sharing one FA cell, LSB first
module FA (
    output logic c_out,
    output logic sum,
    input  logic a,
    input  logic b,
    input  logic c_in
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_alu_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d, result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             arith, sub, fa_sum, fa_cout, bit_v, last, load;

    assign arith = ~op_q[1];
    assign sub   = op_q == 2'b01;
    assign last  = cnt_q == CW'(WIDTH - 1);
    assign load  = bus.start && state_q != RUN;

    // SUB is a + ~b + 1: invert b here, the +1 comes from the preset carry
    FA u_fa (.c_out(fa_cout), .sum(fa_sum), .a(a_sh_q[0]), .b(b_sh_q[0] ^ sub), .c_in(carry_q));

    assign bit_v = arith ? fa_sum : op_q[0] ? a_sh_q[0] ^ b_sh_q[0] : a_sh_q[0] & b_sh_q[0];

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        result_d = result_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        if (state_q == RUN) begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_sh_d = (res_sh_q >> 1) | (WIDTH'(bit_v) << (WIDTH - 1));
            carry_d  = arith & fa_cout;
            cnt_d    = cnt_q + CW'(1);
            if (last) begin
                state_d  = DONE;
                result_d = res_sh_d;
                c_out_d  = arith & fa_cout;
                ovf_d    = arith & (carry_q ^ fa_cout);
                zero_d   = res_sh_d == '0;
            end
        end else begin
            state_d = load ? RUN : IDLE;
            if (load) begin
                a_sh_d   = bus.a;
                b_sh_d   = bus.b;
                op_d     = bus.op;
                res_sh_d = '0;
                carry_d  = bus.op == 2'b01;
                cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.busy   = state_q == RUN;
    assign bus.done   = state_q == DONE;
    assign bus.result = result_q;
    assign bus.c_out  = c_out_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: random and directed operations checked against an arithmetic reference model
module tb_serial_alu_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    serial_alu_ctrl_if #(.WIDTH(W)) bif ();
    serial_alu_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bif));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // {c_out, ovf, zero, result} from plain integer arithmetic
    function automatic logic [10:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, s;
        logic [7:0] r;
        logic c, v;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        c = 1'b0;
        v = 1'b0;
        s = 0;
        case (op)
            2'd0: begin r = 8'(ua + ub); c = (ua + ub) > 255; s = sa + sb; v = s > 127 || s < -128; end
            2'd1: begin r = 8'(ua - ub); c = ua >= ub; s = sa - sb; v = s > 127 || s < -128; end
            2'd2: r = a & b;
            default: r = a ^ b;
        endcase
        return {c, v, r == 8'h00, r};
    endfunction

    function automatic logic [10:0] outs();
        return {bif.c_out, bif.ovf, bif.zero, bif.result};
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input bit noise);
        logic [10:0] exp, snap;
        int n, busy_n;
        exp = model(op, a, b);
        snap = outs();
        bif.start = 1'b1;
        bif.op = op;
        bif.a = a;
        bif.b = b;
        step;
        bif.start = 1'b0;
        n = 0;
        busy_n = 0;
        while (!bif.done && n < 3 * W) begin
            if (bif.busy) busy_n++;
            check("hold_during_run", 32'(outs()), 32'(snap));
            bif.a = 8'($urandom);
            bif.b = 8'($urandom);
            bif.op = 2'($urandom);
            bif.start = noise && ($urandom_range(0, 2) == 0);
            step;
            n++;
        end
        bif.start = 1'b0;
        check("latency", n, W);
        check("busy_cycles", busy_n, W);
        check("done_high", 32'(bif.done), 1);
        check("busy_in_done", 32'(bif.busy), 0);
        check("result_flags", 32'(outs()), 32'(exp));
        step;
        check("done_one_pulse", 32'(bif.done), 0);
    endtask

    task automatic directed(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic c, input logic v, input logic z, input logic [7:0] r);
        run_op(op, a, b, 1'b0);
        check("plan_value", 32'(outs()), 32'({c, v, z, r}));
    endtask

    initial begin
        int n, seen;
        bif.start = 1'b0;
        bif.op = 2'd0;
        bif.a = 8'h00;
        bif.b = 8'h00;
        repeat (2) step;
        rst = 1'b0;
        check("reset_state", 32'({bif.busy, bif.done, outs()}), 0);

        directed(2'd0, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b1, 8'h00);
        directed(2'd0, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 8'h80);
        directed(2'd1, 8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 8'h7F);
        directed(2'd1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 8'hFF);
        directed(2'd3, 8'hA5, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h5A);
        directed(2'd2, 8'hA5, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h00);

        // reset for two cycles from the middle of a run
        directed(2'd0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 8'h46);
        bif.start = 1'b1;
        bif.op = 2'($urandom);
        bif.a = 8'($urandom);
        bif.b = 8'($urandom);
        step;
        bif.start = 1'b0;
        repeat (3) step;
        rst = 1'b1;
        repeat (2) step;
        rst = 1'b0;
        check("reset_mid_run", 32'({bif.busy, bif.done, outs()}), 0);

        // start held high: second op taken in the DONE cycle of the first
        bif.start = 1'b1;
        bif.op = 2'd0;
        bif.a = 8'd3;
        bif.b = 8'd4;
        step;
        n = 0;
        while (!bif.done && n < 3 * W) begin
            bif.op = 2'd1;
            bif.a = 8'd9;
            bif.b = 8'd9;
            step;
            n++;
        end
        check("b2b_first_latency", n, W);
        check("b2b_first_result", 32'(outs()), 32'({1'b0, 1'b0, 1'b0, 8'h07}));
        step;
        bif.start = 1'b0;
        check("b2b_second_accepted", 32'(bif.busy), 1);
        n = 1;
        while (!bif.done && n < 3 * W) begin
            step;
            n++;
        end
        check("b2b_done_gap", n, W + 1);
        check("b2b_second_result", 32'(outs()), 32'({1'b1, 1'b0, 1'b1, 8'h00}));
        step;

        // abort on the 4th RUN cycle
        directed(2'd0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 8'h33);
        bif.start = 1'b1;
        bif.op = 2'd0;
        bif.a = 8'h10;
        bif.b = 8'h20;
        step;
        bif.start = 1'b0;
        repeat (3) step;
        rst = 1'b1;
        step;
        check("abort_outputs", 32'({bif.busy, bif.done, outs()}), 0);
        rst = 1'b0;
        seen = 0;
        repeat (3 * W) begin
            if (bif.done) seen++;
            step;
        end
        check("abort_no_done", seen, 0);
        directed(2'd0, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 8'h30);

        repeat (40) run_op(2'($urandom), 8'($urandom), 8'($urandom), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
